// File: rtl/load_store_unit_pkg.sv
// Shared constants, FSM state type and the sub-word merge helper for the
// load/store unit.
package lsu_pkg;

  localparam int WORD_W = 32;
  localparam int BYTE_W = 8;
  localparam int LANES  = WORD_W / BYTE_W;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    RMW_WRITE,
    FAULT_HOLD
  } state_t;

  // Replace the addressed byte or halfword of old_word with the low bits of data.
  function automatic logic [WORD_W-1:0] merge_lane(
    input logic [WORD_W-1:0] old_word,
    input logic [WORD_W-1:0] data,
    input logic [1:0]        offset,
    input logic              half
  );
    logic [WORD_W-1:0] merged;
    merged = old_word;
    if (half) merged[{offset[1], 4'b0000} +: 16] = data[15:0];
    else      merged[{offset, 3'b000} +: BYTE_W] = data[BYTE_W-1:0];
    return merged;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Core-side request bus and data_memory port of the load/store unit.
interface load_store_unit_if;
  import lsu_pkg::*;

  logic              req_valid;
  logic              req_write;
  logic [2:0]        funct3;
  logic [WORD_W-1:0] addr;
  logic [WORD_W-1:0] wdata;
  logic [WORD_W-1:0] rdata;
  logic              stall;
  logic              done;
  logic              fault;

  logic [WORD_W-1:0] mem_address;
  logic [WORD_W-1:0] mem_write_data;
  logic              mem_Memwrite;
  logic              mem_Memread;
  logic [WORD_W-1:0] mem_read_data;

  modport slave (
    input  req_valid, req_write, funct3, addr, wdata, mem_read_data,
    output rdata, stall, done, fault,
           mem_address, mem_write_data, mem_Memwrite, mem_Memread
  );

  modport master (
    output req_valid, req_write, funct3, addr, wdata, mem_read_data,
    input  rdata, stall, done, fault,
           mem_address, mem_write_data, mem_Memwrite, mem_Memread
  );

endinterface

// File: rtl/load_store_unit_load_extend.sv
// Selects the addressed byte/halfword lane of a memory word and sign- or
// zero-extends it according to funct3.
module load_extend
  import lsu_pkg::*;
(
  input  logic [WORD_W-1:0] word,
  input  logic [1:0]        offset,
  input  logic [2:0]        funct3,
  output logic [WORD_W-1:0] value
);

  logic [BYTE_W-1:0] byte_lane;
  logic [15:0]       half_lane;

  assign byte_lane = word[{offset, 3'b000} +: BYTE_W];
  assign half_lane = word[{offset[1], 4'b0000} +: 16];

  always_comb begin
    value = '0;
    case (funct3)
      F3_B:    value = {{(WORD_W-BYTE_W){byte_lane[BYTE_W-1]}}, byte_lane};
      F3_H:    value = {{(WORD_W-16){half_lane[15]}}, half_lane};
      F3_W:    value = word;
      F3_BU:   value = {{(WORD_W-BYTE_W){1'b0}}, byte_lane};
      F3_HU:   value = {{(WORD_W-16){1'b0}}, half_lane};
      default: value = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: single-cycle loads and word stores, two-cycle
// read-modify-write for byte/halfword stores, one-cycle fault reporting.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DEPTH_WORDS = 32
) (
  input  logic               clk,
  input  logic               reset,
  load_store_unit_if.slave   bus
);

  state_t            state, next_state;
  logic [WORD_W-1:0] merge_q, merge_d;
  logic [29:0]       addr_q, addr_d;
  logic [WORD_W-1:0] load_value;
  logic              legal;
  logic              in_range;

  load_extend u_load_extend (
    .word   (bus.mem_read_data),
    .offset (bus.addr[1:0]),
    .funct3 (bus.funct3),
    .value  (load_value)
  );

  assign in_range = ({2'b00, bus.addr[31:2]} < 32'(DEPTH_WORDS));

  always_comb begin
    legal = 1'b0;
    case (bus.funct3)
      F3_B:    legal = 1'b1;
      F3_H:    legal = !bus.addr[0];
      F3_W:    legal = (bus.addr[1:0] == 2'b00);
      F3_BU:   legal = !bus.req_write;
      F3_HU:   legal = !bus.req_write && !bus.addr[0];
      default: legal = 1'b0;
    endcase
    if (!in_range) legal = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      merge_q <= '0;
      addr_q  <= '0;
    end else begin
      state   <= next_state;
      merge_q <= merge_d;
      addr_q  <= addr_d;
    end
  end

  // The word index is captured for the write-back cycle because the core is
  // released (stall low) while RMW_WRITE completes and may change addr.
  always_comb begin
    next_state         = state;
    merge_d            = merge_q;
    addr_d             = addr_q;
    bus.rdata          = '0;
    bus.stall          = 1'b0;
    bus.done           = 1'b0;
    bus.fault          = 1'b0;
    bus.mem_Memread    = 1'b0;
    bus.mem_Memwrite   = 1'b0;
    bus.mem_address    = {2'b00, bus.addr[31:2]};
    bus.mem_write_data = bus.wdata;

    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          if (!legal) begin
            bus.fault  = 1'b1;
            next_state = FAULT_HOLD;
          end else if (!bus.req_write) begin
            bus.mem_Memread = 1'b1;
            bus.rdata       = load_value;
            bus.done        = 1'b1;
          end else if (bus.funct3 == F3_W) begin
            bus.mem_Memwrite = 1'b1;
            bus.done         = 1'b1;
          end else begin
            bus.mem_Memread = 1'b1;
            bus.stall       = 1'b1;
            merge_d         = merge_lane(bus.mem_read_data, bus.wdata,
                                         bus.addr[1:0], bus.funct3 == F3_H);
            addr_d          = bus.addr[31:2];
            next_state      = RMW_WRITE;
          end
        end
      end

      RMW_WRITE: begin
        bus.mem_address    = {2'b00, addr_q};
        bus.mem_write_data = merge_q;
        bus.mem_Memwrite   = !reset;
        bus.done           = !reset;
        next_state         = IDLE;
      end

      FAULT_HOLD: begin
        bus.stall  = 1'b1;
        next_state = IDLE;
      end

      default: next_state = IDLE;
    endcase
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 32, number of 32-bit words in the attached data_memory.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on posedge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port req_valid  input  1  memory instruction present this cycle.
REQ-005 SHALL have port req_write  input  1  1 = store, 0 = load.
REQ-006 SHALL have port funct3  input  3  access size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu.
REQ-007 SHALL have port addr  input  32  byte address from ALU.
REQ-008 SHALL have port wdata  input  32  store data from register file rd2.
REQ-009 SHALL have port rdata  output  32  extended load result to writeback mux.
REQ-010 SHALL have port stall  output  1  core must hold PC and all req_* inputs while high.
REQ-011 SHALL have port done  output  1  one-cycle pulse on completion of an access.
REQ-012 SHALL have port fault  output  1  one-cycle pulse on misaligned, illegal or out-of-range access.
REQ-013 SHALL have ports mem_address out 32, mem_write_data out 32, mem_Memwrite out 1, mem_Memread out 1, mem_read_data in 32, connecting to data_memory (word-indexed, combinational read, posedge write).

Function
REQ-014 SHALL drive mem_address = {2'b00, addr[31:2]}, a word index.
REQ-015 SHALL raise fault for exactly one cycle with no memory read/write when: h/hu/sh with addr[0]=1; w/sw with addr[1:0]!=0; funct3 outside the listed codes (011, 110, 111; 100/101 with req_write=1); or addr[31:2] >= DEPTH_WORDS.
REQ-016 SHALL use FSM states IDLE, RMW_WRITE, FAULT_HOLD.
REQ-017 Loads (IDLE): SHALL assert mem_Memread, extract byte/halfword lane addr[1:0], sign- or zero-extend per funct3, drive rdata combinationally, and pulse done in the same cycle; stall=0.
REQ-018 Word store (IDLE): SHALL assert mem_Memwrite with mem_write_data=wdata in the same cycle and pulse done; stall=0.
REQ-019 Sub-word store, cycle 1 (IDLE): SHALL assert mem_Memread, register the merged word (old word with addressed lane replaced by wdata[7:0] or wdata[15:0]), assert stall, and go to RMW_WRITE.
REQ-020 Sub-word store, cycle 2 (RMW_WRITE): SHALL assert mem_Memwrite with the registered merged word, deassert stall, pulse done, and return to IDLE; latency 2 cycles.
REQ-021 In RMW_WRITE the write SHALL complete even if req_valid falls; inputs are ignored in this state.
REQ-022 Fault SHALL enter FAULT_HOLD for one cycle with stall=1, then return to IDLE; no memory strobes in either cycle.
REQ-023 With req_valid=0 in IDLE, mem_Memread, mem_Memwrite, stall, done, fault SHALL all be 0 and rdata SHALL be 0.
REQ-024 mem_Memread and mem_Memwrite SHALL never be asserted in the same cycle.
REQ-025 rdata SHALL be 0 during all stores and faults.

Reset
REQ-026 On reset, state SHALL go to IDLE and the merge register SHALL clear to 0; stall, done, fault, mem_Memwrite, mem_Memread SHALL be 0 in the cycle following reset.
REQ-027 Reset asserted in RMW_WRITE SHALL suppress the pending write (mem_Memwrite held 0 on that edge).

Structure
REQ-028 Package lsu_pkg SHALL hold funct3 code constants, the FSM state enum, and the word/byte-lane width constants.
REQ-029 One sub-module, load_extend (combinational lane select plus sign/zero extension), SHALL be instantiated; all other logic SHALL be in load_store_unit.

Verification
REQ-030 Memory word 3 = 32'h8899AABB; lb addr=32'h0000000D -> rdata=32'hFFFFFFAA, done same cycle, stall=0.
REQ-031 Same word; lhu addr=32'h0000000E -> rdata=32'h00008899; lh -> 32'hFFFF8899.
REQ-032 Word 3 = 32'h8899AABB; sb addr=32'h0000000C, wdata=32'h12345677 -> stall 1 cycle, then word 3 = 32'h8899AA77, done on cycle 2.
REQ-033 sw addr=32'h00000006 -> fault pulse, stall 1 cycle, no write, memory unchanged; lw addr=32'h00000080 (DEPTH_WORDS=32) -> fault.
REQ-034 sh addr=32'h00000010 with reset asserted on the RMW_WRITE cycle -> word 4 unchanged, FSM IDLE, stall=0.
REQ-035 Back-to-back sb to word 5 lanes 0 then 1 -> both bytes merged, each store taking 2 cycles, no lost update.
